knn_merge_scheduler: RTL and testbench
======================================

// Module: knn_merge_scheduler
// PURPOSE
//  Sequences the phase-1 -> phase-2 merge of the KNN sorter. After the distance stream ends (done high,
//  wr_en quiet), it walks the enabled phase-1 channels in ascending index order. For each one it enables
//  the channel output, drives the channel select and streams exactly K beats into phase 2.
//  It then raises final_out_en so phase 2 presents the global K nearest.
// PARAMETERS
//  NUM_CH        1   number of phase-1 sorter channels (1..256)
//  K             1   neighbours held per channel; beats transferred per channel (1..65535)
//  DRAIN_CYCLES  10  consecutive wr_en-low cycles required before merging (pipeline flush), >=1
// PORTS
//  clk           in   1          system clock, rising edge
//  reset         in   1          asynchronous, active-low (0 = reset asserted)
//  done          in   1          distance stream complete; level, held high for the whole merge
//  wr_en         in   1          distance pipeline write activity
//  ch_mask       in   NUM_CH     1 = channel participates; sampled on DRAIN->first-channel transition
//  p2_ready      in   1          phase 2 accepts a beat this cycle
//  ch_out_en     out  NUM_CH     one-hot channel output enable (0 when no channel selected)
//  ch_select     out  8          index of the channel being transferred
//  p2_valid      out  1          beat offered to phase 2
//  final_out_en  out  1          merge complete; phase-2 output enable
//  busy          out  1          high in DRAIN/XFER/GAP
// BEHAVIOUR
//  - All outputs are registered. Reset values: ch_out_en=0, ch_select=0, p2_valid=0, final_out_en=0, busy=0;
//    state=IDLE, counters=0. Reset is honoured in any state, mid-transfer included; no partial state survives.
//  - States: IDLE, DRAIN, XFER, GAP, FINAL.
//  - IDLE: done=1 -> DRAIN with drain_cnt cleared.
//  - DRAIN: drain_cnt increments on each wr_en=0 cycle; wr_en=1 clears it.
//    drain_cnt==DRAIN_CYCLES-1 with wr_en=0 -> latch ch_mask.
//    If the mask is nonzero, go to XFER on the lowest set bit. If the mask is zero, go straight to FINAL.
//  - XFER: ch_select=ch, ch_out_en=1<<ch, p2_valid=1.
//    A beat counts only when p2_valid&&p2_ready; while p2_ready=0 every output holds.
//    The K-th accepted beat exits XFER (exactly K beats, never K+1).
//    If a higher masked-in channel remains -> GAP. Otherwise -> FINAL.
//  - GAP: one cycle with p2_valid=0 and ch_out_en=0 while phase-1 output settles.
//    Then XFER on the next set bit; the beat counter is cleared. ch_select advances on GAP exit.
//  - FINAL: final_out_en=1, ch_out_en=0, p2_valid=0. Held until done=0, then IDLE and final_out_en=0.
//  - done falling in DRAIN/XFER/GAP: abort to IDLE next cycle, all outputs cleared, no final_out_en.
//  - wr_en during XFER/GAP is ignored. done and wr_en both high in IDLE still enter DRAIN (drain_cnt stays 0).
//  - Channel walk does not wrap; channel NUM_CH-1 is the last candidate.
//  - Beat counter width = $clog2(K+1); drain counter width = $clog2(DRAIN_CYCLES+1).
//  - Latency: done high plus quiet wr_en -> first p2_valid after DRAIN_CYCLES+1 cycles.
//    Total merge with p2_ready tied high = DRAIN_CYCLES+1 + N*K + (N-1), where N = popcount(mask).
// CONFIGURATION
//  KNN_MERGE_PERF_EN defined: adds output merge_cycles[31:0]. It clears on IDLE->DRAIN, counts every cycle
//    in DRAIN/XFER/GAP, saturates at 32'hFFFF_FFFF, and holds through FINAL. Reset value is 0.
//  Undefined: port and counter are absent; behaviour is otherwise identical.
// TESTING
//  - NUM_CH=4,K=3,DRAIN=10, mask=4'hF, p2_ready=1, done rises with wr_en=0 -> ch0..ch3 each give exactly 3
//    p2_valid beats, 1-cycle gaps, final_out_en at cycle 11+12+3=26; merge_cycles=26 (PERF_EN).
//  - Same config, wr_en pulses high at drain cycle 7 -> drain restarts; first p2_valid 11 cycles after pulse.
//  - mask=4'b1010 -> only ch_select=1 then 3 transferred, ch_out_en 4'b0010 then 4'b1000; mask=0 -> FINAL
//    directly after drain, zero beats.
//  - p2_ready low for 5 cycles mid ch2 after beat 1 -> outputs frozen, ch2 still delivers exactly 3 accepted beats.
//  - done dropped during ch1 XFER -> next cycle all outputs 0, state IDLE, final_out_en never asserted.
//  - reset asserted (0) asynchronously during ch2 XFER -> outputs 0 without a clock edge; after release
//    and done re-raise, a full merge from ch0 completes normally.

Source files
------------

// File: rtl/knn_merge_scheduler.sv
// Phase-1 -> phase-2 merge sequencer for the KNN sorter: drains the distance pipeline, then streams K beats per enabled channel.
// Optional KNN_MERGE_PERF_EN adds a saturating merge_cycles counter output.
module knn_merge_scheduler #(
  parameter int NUM_CH       = 1,
  parameter int K            = 1,
  parameter int DRAIN_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic              wr_en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              p2_ready,
  output logic [NUM_CH-1:0] ch_out_en,
  output logic [7:0]        ch_select,
  output logic              p2_valid,
  output logic              final_out_en,
  output logic              busy
`ifdef KNN_MERGE_PERF_EN
  ,
  output logic [31:0]       merge_cycles
`endif
);

  localparam int BW = $clog2(K + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [BW-1:0] K_LAST = BW'(K - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, XFER, GAP, FINAL} state_t;

  state_t            state_q;
  logic [BW-1:0]     beat_q;
  logic [DW-1:0]     drain_q;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] ch_oe_q;
  logic [7:0]        ch_sel_q;
  logic              valid_q;
  logic              final_q;
  logic              busy_q;

  logic              first_found;
  logic [7:0]        first_ch;
  logic              next_found;
  logic [7:0]        next_ch;

  // Downward scans so the last hit is the lowest qualifying index.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_found = 1'b1;
        first_ch    = 8'(i);
      end
      if (mask_q[i] && (i > int'(ch_sel_q))) begin
        next_found = 1'b1;
        next_ch    = 8'(i);
      end
    end
  end

  function automatic logic [NUM_CH-1:0] onehot(input logic [7:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      drain_q  <= '0;
      mask_q   <= '0;
      ch_oe_q  <= '0;
      ch_sel_q <= '0;
      valid_q  <= 1'b0;
      final_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (!done && (state_q == DRAIN || state_q == XFER || state_q == GAP)) begin
      // Losing done mid-merge abandons everything; phase 2 never sees final_out_en.
      state_q  <= IDLE;
      beat_q   <= '0;
      drain_q  <= '0;
      mask_q   <= '0;
      ch_oe_q  <= '0;
      ch_sel_q <= '0;
      valid_q  <= 1'b0;
      final_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (done) begin
            state_q <= DRAIN;
            drain_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (wr_en) begin
            drain_q <= '0;
          end else if (drain_q == D_LAST) begin
            drain_q <= '0;
            mask_q  <= ch_mask;
            beat_q  <= '0;
            if (first_found) begin
              state_q  <= XFER;
              ch_sel_q <= first_ch;
              ch_oe_q  <= onehot(first_ch);
              valid_q  <= 1'b1;
            end else begin
              state_q <= FINAL;
              final_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        XFER: begin
          if (p2_ready) begin
            if (beat_q == K_LAST) begin
              beat_q  <= '0;
              valid_q <= 1'b0;
              ch_oe_q <= '0;
              if (next_found) begin
                state_q <= GAP;
              end else begin
                state_q <= FINAL;
                final_q <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        GAP: begin
          state_q  <= XFER;
          beat_q   <= '0;
          ch_sel_q <= next_ch;
          ch_oe_q  <= onehot(next_ch);
          valid_q  <= 1'b1;
        end
        FINAL: begin
          if (!done) begin
            state_q  <= IDLE;
            final_q  <= 1'b0;
            ch_sel_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_out_en    = ch_oe_q;
  assign ch_select    = ch_sel_q;
  assign p2_valid     = valid_q;
  assign final_out_en = final_q;
  assign busy         = busy_q;

`ifdef KNN_MERGE_PERF_EN
  logic [31:0] perf_q;

  // The IDLE->DRAIN cycle counts as the first merge cycle, so the total matches done-to-final latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (state_q == IDLE && done) begin
      perf_q <= 32'd1;
    end else if ((state_q == DRAIN || state_q == XFER || state_q == GAP) && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign merge_cycles = perf_q;
`endif

endmodule

// File: tb/tb_knn_merge_scheduler.sv
// Randomized/directed bench for knn_merge_scheduler with a transaction-level reference (expected beat queue + latency formula).
module tb_knn_merge_scheduler;
  localparam int NCH = 4;
  localparam int KB  = 3;
  localparam int D   = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           done = 1'b0;
  logic           wr_en = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic           p2_ready = 1'b0;
  logic [NCH-1:0] ch_out_en;
  logic [7:0]     ch_select;
  logic           p2_valid;
  logic           final_out_en;
  logic           busy;
`ifdef KNN_MERGE_PERF_EN
  logic [31:0]    merge_cycles;
`endif

  int checks = 0;
  int errors = 0;

  knn_merge_scheduler #(.NUM_CH(NCH), .K(KB), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .done(done), .wr_en(wr_en), .ch_mask(ch_mask),
    .p2_ready(p2_ready), .ch_out_en(ch_out_en), .ch_select(ch_select),
    .p2_valid(p2_valid), .final_out_en(final_out_en), .busy(busy)
`ifdef KNN_MERGE_PERF_EN
    , .merge_cycles(merge_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_oe"}, 32'(ch_out_en), 0);
    check({tag, "_sel"}, 32'(ch_select), 0);
    check({tag, "_valid"}, 32'(p2_valid), 0);
    check({tag, "_final"}, 32'(final_out_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // ready_mode: 0 always ready, 1 random, 2 five-cycle stall after ch2 beat 1.
  // abort_mode: 0 none, 1 drop done in ch1, 2 async reset in ch2.
  task automatic run_merge(input logic [NCH-1:0] mask, input int ready_mode, input int pulse,
                           input bit idle_wr, input int abort_mode);
    int exp_q[$];
    int n = 0, stalls = 0, cyc = 0, first_v = -1, ch2_acc = 0, stall_left = 5, off, exp_final;
    bit rdy, prev_stall = 0, finished = 0;
    logic [7:0] prev_sel = '0;
    logic [NCH-1:0] oh;
    for (int c = 0; c < NCH; c++)
      if (mask[c]) begin
        n++;
        for (int b = 0; b < KB; b++) exp_q.push_back(c);
      end
    off = (pulse >= 1 && pulse <= D) ? pulse : 0;
    done = 1'b1; wr_en = idle_wr; ch_mask = mask; p2_ready = 1'b1;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      wr_en = (cyc == pulse);
      if (prev_stall) begin
        check("hold_valid", 32'(p2_valid), 1);
        check("hold_sel", 32'(ch_select), 32'(prev_sel));
      end
      if (p2_valid) begin
        oh = NCH'(1) << ch_select;
        check("onehot", 32'(ch_out_en), 32'(oh));
        if (first_v < 0) begin
          first_v = cyc;
          check("first_valid_cyc", cyc, D + 1 + off);
        end
      end else if (!final_out_en) begin
        check("oe_idle", 32'(ch_out_en), 0);
      end
      if (abort_mode == 1 && p2_valid && ch_select == 8'd1) begin
        done = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        repeat (5) begin
          @(negedge clk);
          check("abort_no_final", 32'(final_out_en), 0);
        end
        return;
      end
      if (abort_mode == 2 && p2_valid && ch_select == 8'd2) begin
        #2 reset = 1'b0;
        #1 check_idle_outputs("async_rst");
        done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (final_out_en) begin
        finished = 1;
        exp_final = (n == 0) ? D + 1 + off : D + 1 + off + n * KB + (n - 1) + stalls;
        check("final_cyc", cyc, exp_final);
        check("beats_left", exp_q.size(), 0);
        check("final_oe", 32'(ch_out_en), 0);
        check("final_valid", 32'(p2_valid), 0);
        if (n == 0) check("zero_beats", first_v, -1);
`ifdef KNN_MERGE_PERF_EN
        check("merge_cycles", merge_cycles, exp_final);
`endif
      end else begin
        check("busy", 32'(busy), 1);
        case (ready_mode)
          1: rdy = ($urandom_range(0, 3) != 0);
          2: begin
            rdy = 1'b1;
            if (p2_valid && ch_select == 8'd2 && ch2_acc == 1 && stall_left > 0) begin
              rdy = 1'b0;
              stall_left--;
            end
          end
          default: rdy = 1'b1;
        endcase
        p2_ready = rdy;
        prev_stall = p2_valid && !rdy;
        prev_sel = ch_select;
        if (p2_valid && !rdy) stalls++;
        if (p2_valid && rdy) begin
          check("beat_ch", 32'(ch_select), exp_q.size() > 0 ? exp_q.pop_front() : 32'hEE);
          if (ch_select == 8'd2) ch2_acc++;
        end
      end
    end
    if (!finished) check("timeout_final", 32'(final_out_en), 1);
    done = 1'b0; wr_en = 1'b0; p2_ready = 1'b1;
    @(negedge clk);
    check("release_final", 32'(final_out_en), 0);
    check("release_busy", 32'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    run_merge(4'hF, 0, -1, 1'b0, 0);
    run_merge(4'hF, 0, 7, 1'b0, 0);
    run_merge(4'b1010, 0, -1, 1'b0, 0);
    run_merge(4'h0, 0, -1, 1'b0, 0);
    run_merge(4'hF, 2, -1, 1'b1, 0);
    run_merge(4'hF, 0, -1, 1'b0, 1);
    run_merge(4'hF, 0, -1, 1'b0, 2);
    run_merge(4'hF, 0, -1, 1'b0, 0);
    repeat (8) begin
      run_merge(NCH'($urandom_range(0, 15)), 1, $urandom_range(1, 20), 1'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
